// File: rtl/bw_io_hstl_rx_edgelogic.sv
// bw_io_hstl_rx_edgelogic: HSTL pad receive path with synchronizer, deglitch filter, edge pulses and BSR/scan hooks
module bw_io_hstl_rx_edgelogic #(
   parameter int   SYNC_STAGES = 2,
   parameter int   FILT_CNT_W  = 3,
   parameter int   FILT_THRESH = 4,
   parameter logic IDLE_VAL    = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic pad_data,
   input  logic ie,
   input  logic filt_en,
   input  logic se,
   input  logic si,
   input  logic bsr_mode,
   input  logic bsr_data_to_core,
   input  logic por_l,
   output logic to_core,
   output logic rise_pls,
   output logic fall_pls,
   output logic bsr_capture,
   output logic so,
   output logic por
);
   typedef enum logic {STABLE, QUAL} state_e;
   localparam logic [FILT_CNT_W-1:0] THR_M1 = FILT_CNT_W'(FILT_THRESH - 1);
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [FILT_CNT_W-1:0]  cnt_q, cnt_d;
   logic                   filt_q, filt_d, prev_q, prev_d, s;
   state_e                 state;
   assign s     = sync_q[SYNC_STAGES-1];
   assign state = (cnt_q == '0) ? STABLE : QUAL;
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], se ? si : (ie ? pad_data : IDLE_VAL)};
      prev_d = filt_q;
      filt_d = filt_q;
      cnt_d  = cnt_q;
      if (se)
         filt_d = s;
      else if (!filt_en) begin
         filt_d = s;
         cnt_d  = '0;
      end else if (state == STABLE) begin
         if (s != filt_q) begin
            if (FILT_THRESH == 1) filt_d = s;
            else cnt_d = FILT_CNT_W'(1);
         end
      end else if (s == filt_q)
         cnt_d = '0;
      else if (cnt_q == THR_M1) begin
         filt_d = s;
         cnt_d  = '0;
      end else
         cnt_d = cnt_q + 1'b1;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= {SYNC_STAGES{IDLE_VAL}};
         filt_q <= IDLE_VAL;
         prev_q <= IDLE_VAL;
         cnt_q  <= '0;
      end else begin
         sync_q <= sync_d;
         filt_q <= filt_d;
         prev_q <= prev_d;
         cnt_q  <= cnt_d;
      end
   end
   assign to_core     = bsr_mode ? bsr_data_to_core : filt_q;
   assign rise_pls    = filt_q & ~prev_q & ~se;
   assign fall_pls    = ~filt_q & prev_q & ~se;
   assign bsr_capture = s;
   assign so          = filt_q;
   assign por         = ~por_l;
endmodule

// File: tb/tb_bw_io_hstl_rx_edgelogic.sv
// tb_bw_io_hstl_rx_edgelogic: directed bench for the HSTL receive edge logic (defaults: 2 sync stages, threshold 4, idle 1)
module tb_bw_io_hstl_rx_edgelogic;
   logic clk = 1'b0;
   logic rst, pad_data, ie, filt_en, se, si, bsr_mode, bsr_data_to_core, por_l;
   logic to_core, rise_pls, fall_pls, bsr_capture, so, por;
   int checks = 0, failures = 0;

   bw_io_hstl_rx_edgelogic dut (
      .clk(clk), .rst(rst), .pad_data(pad_data), .ie(ie), .filt_en(filt_en),
      .se(se), .si(si), .bsr_mode(bsr_mode), .bsr_data_to_core(bsr_data_to_core),
      .por_l(por_l), .to_core(to_core), .rise_pls(rise_pls), .fall_pls(fall_pls),
      .bsr_capture(bsr_capture), .so(so), .por(por)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1; pad_data = 0; ie = 1; filt_en = 0; se = 0; si = 0;
      bsr_mode = 0; bsr_data_to_core = 0; por_l = 1;
      tick(2);
      chk("rst_to_core", to_core, 1);
      chk("rst_so", so, 1);
      chk("rst_rise", rise_pls, 0);
      chk("rst_fall", fall_pls, 0);
      chk("rst_cap", bsr_capture, 1);
      chk("rst_por", por, 0);
      chk("rst_cnt", dut.cnt_q, 0);
      // filter off: falling step reaches to_core on the 3rd edge
      rst = 0; pad_data = 1;
      tick(3);
      chk("nf_pre", to_core, 1);
      pad_data = 0;
      tick();
      chk("nf_t1", to_core, 1);
      chk("nf_t1_fall", fall_pls, 0);
      tick();
      chk("nf_t2", to_core, 1);
      chk("nf_t2_cap", bsr_capture, 0);
      tick();
      chk("nf_t3", to_core, 0);
      chk("nf_t3_fall", fall_pls, 1);
      tick();
      chk("nf_t4_fall", fall_pls, 0);
      chk("nf_t4", to_core, 0);
      // back to 1, then arm filter and send a 3-sample glitch
      pad_data = 1;
      tick(3);
      chk("nf_rise_t3", rise_pls, 1);
      chk("nf_hi", to_core, 1);
      tick();
      filt_en = 1; pad_data = 0;
      tick(3);
      pad_data = 1;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("gl_to_core", to_core, 1);
         chk("gl_fall", fall_pls, 0);
      end
      chk("gl_cnt_peak", dut.cnt_q, 3);
      tick();
      chk("gl_to_core_end", to_core, 1);
      chk("gl_cnt_clr", dut.cnt_q, 0);
      chk("gl_rise", rise_pls, 0);
      tick(2);
      // qualified falling edge: 6 edges after the step
      pad_data = 0;
      for (int i = 1; i <= 5; i++) begin
         tick();
         chk("q_hold", to_core, 1);
         chk("q_hold_fall", fall_pls, 0);
      end
      tick();
      chk("q_t6", to_core, 0);
      chk("q_t6_fall", fall_pls, 1);
      tick();
      chk("q_t7_fall", fall_pls, 0);
      tick(3);
      chk("q_t10", to_core, 0);
      // leave cnt mid-qualification, then scan
      pad_data = 1;
      tick(3);
      chk("pre_scan_cnt", dut.cnt_q, 1);
      se = 1; si = 1;
      tick();
      chk("sc1_rise", rise_pls, 0);
      chk("sc1_so", so, 1);
      si = 0;
      tick();
      chk("sc2_cnt", dut.cnt_q, 1);
      si = 1;
      tick();
      chk("sc3_so", so, 1);
      si = 0;
      tick();
      chk("sc4_so", so, 0);
      chk("sc4_fall", fall_pls, 0);
      si = 0;
      tick();
      chk("sc5_so", so, 1);
      chk("sc5_rise", rise_pls, 0);
      chk("sc5_cnt", dut.cnt_q, 1);
      chk("sc5_cap", bsr_capture, 0);
      rst = 1;
      tick();
      chk("scrst_so", so, 1);
      chk("scrst_cap", bsr_capture, 1);
      chk("scrst_cnt", dut.cnt_q, 0);
      // BSR, ie and por
      rst = 0; se = 0; filt_en = 0; pad_data = 1;
      tick(3);
      chk("bsr_pre", to_core, 1);
      bsr_mode = 1; bsr_data_to_core = 0;
      #1;
      chk("bsr_override", to_core, 0);
      pad_data = 0;
      tick(2);
      chk("bsr_cap_track", bsr_capture, 0);
      tick();
      bsr_data_to_core = 1;
      #1;
      chk("bsr_data1", to_core, 1);
      bsr_mode = 0;
      #1;
      chk("bsr_filt_tracked", to_core, 0);
      ie = 0;
      tick();
      chk("ie_t1", bsr_capture, 0);
      tick();
      chk("ie_t2", bsr_capture, 1);
      por_l = 0;
      #1;
      chk("por_on", por, 1);
      por_l = 1;
      #1;
      chk("por_off", por, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
